// File: rtl/puf_ctrl_pkg.sv
// Shared types and default constants for the PUF challenge sequencer.
package puf_ctrl_pkg;

    // One evaluation walks SETUP -> SETTLE -> RACE -> RECORD once per response bit.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SETTLE,
        RACE,
        RECORD,
        DONE
    } seq_state_t;

    localparam int RESP_BITS_D  = 8;
    localparam int SEL_W_D      = 3;
    localparam int SETTLE_CYC_D = 4;
    localparam int TIMEOUT_W_D  = 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal, async reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous level through two flops before anyone looks at it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences one delay-PUF evaluation: per response bit, select an RO pair,
// settle, race the two edge counters and record which one finished first.
module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int RESP_BITS  = RESP_BITS_D,
    parameter int SEL_W      = SEL_W_D,
    parameter int SETTLE_CYC = SETTLE_CYC_D,
    parameter int TIMEOUT_W  = TIMEOUT_W_D
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [RESP_BITS*2*SEL_W-1:0] i_challenge,
    input  logic                         i_fin_a,
    input  logic                         i_fin_b,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [RESP_BITS-1:0]         o_response,
    output logic                         o_tie_err,
    output logic                         o_tmo_err,
    output logic [SEL_W-1:0]             o_mux_sel_a,
    output logic [SEL_W-1:0]             o_mux_sel_b,
    output logic                         o_ro_en,
    output logic                         o_cnt_clr,
    output logic                         o_cnt_en
);

    localparam int CH_W  = RESP_BITS * 2 * SEL_W;
    localparam int CH_AW = (CH_W > 1) ? $clog2(CH_W) : 1;
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(RESP_BITS - 1);
    localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] WD_MAX      = {TIMEOUT_W{1'b1}};
    // Trip one short of all-ones so a race spans exactly 2**TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] WD_TRIP     = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    seq_state_t r_state;
    seq_state_t w_next;

    logic [TIMEOUT_W-1:0] r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [CH_W-1:0]      r_chal;
    logic [RESP_BITS-1:0] r_resp;
    logic                 r_tie;
    logic                 r_tmo;
    logic [SEL_W-1:0]     r_sel_a;
    logic [SEL_W-1:0]     r_sel_b;

    logic                 w_fin_a;
    logic                 w_fin_b;
    logic                 w_settle_end;
    logic                 w_tmo_hit;
    logic                 w_race_end;
    logic                 w_last;
    logic [IDX_W-1:0]     w_nxt_idx;
    logic [CH_AW-1:0]     w_base_a;
    logic [CH_AW-1:0]     w_base_b;

    sync_2ff u_sync_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_fin_a),
        .o_q     (w_fin_a)
    );

    sync_2ff u_sync_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_fin_b),
        .o_q     (w_fin_b)
    );

    assign w_settle_end = (r_cnt == SETTLE_LAST);
    assign w_tmo_hit    = (r_cnt == WD_TRIP);
    assign w_race_end   = w_fin_a | w_fin_b | w_tmo_hit;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_nxt_idx    = r_idx + 1'b1;
    assign w_base_a     = CH_AW'(w_nxt_idx) * CH_AW'(2 * SEL_W);
    assign w_base_b     = w_base_a + CH_AW'(SEL_W);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state and datapath controls; counters sit cleared unless racing or recording.
    always_comb begin
        w_next    = r_state;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        o_ro_en   = 1'b0;
        o_cnt_clr = 1'b1;
        o_cnt_en  = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = SETUP;
            end
            SETUP: begin
                w_next = SETTLE;
            end
            SETTLE: begin
                o_ro_en = 1'b1;
                if (w_settle_end) w_next = RACE;
            end
            RACE: begin
                o_ro_en   = 1'b1;
                o_cnt_clr = 1'b0;
                o_cnt_en  = 1'b1;
                if (w_race_end) w_next = RECORD;
            end
            RECORD: begin
                o_cnt_clr = 1'b0;
                w_next    = w_last ? DONE : SETUP;
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    // Shared settle/watchdog counter: zeroed on every state change, saturates otherwise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                r_cnt <= '0;
        else if (w_next != r_state) r_cnt <= '0;
        else if (r_cnt != WD_MAX)   r_cnt <= r_cnt + 1'b1;
    end

    // Challenge latch, mux selects, bit index and response/error capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_chal  <= '0;
            r_idx   <= '0;
            r_resp  <= '0;
            r_tie   <= 1'b0;
            r_tmo   <= 1'b0;
            r_sel_a <= '0;
            r_sel_b <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_chal  <= i_challenge;
                        r_idx   <= '0;
                        r_resp  <= '0;
                        r_tie   <= 1'b0;
                        r_tmo   <= 1'b0;
                        r_sel_a <= i_challenge[SEL_W-1:0];
                        r_sel_b <= i_challenge[2*SEL_W-1:SEL_W];
                    end
                end
                RACE: begin
                    // A win (even a lone one coinciding with the watchdog) beats a timeout.
                    if (w_race_end) begin
                        r_resp[r_idx] <= w_fin_a & ~w_fin_b;
                        if (w_fin_a & w_fin_b)         r_tie <= 1'b1;
                        else if (!w_fin_a && !w_fin_b) r_tmo <= 1'b1;
                    end
                end
                RECORD: begin
                    // Selects move on the edge into SETUP, so they are stable for SETTLE+RACE.
                    if (!w_last) begin
                        r_idx   <= w_nxt_idx;
                        r_sel_a <= r_chal[w_base_a +: SEL_W];
                        r_sel_b <= r_chal[w_base_b +: SEL_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_response  = r_resp;
    assign o_tie_err   = r_tie;
    assign o_tmo_err   = r_tmo;
    assign o_mux_sel_a = r_sel_a;
    assign o_mux_sel_b = r_sel_b;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: counter emulation, per-cycle monitor against a race-outcome model,
// plus directed runs with literal expectations.
module tb_puf_challenge_sequencer;

    localparam int RB = 8;
    localparam int SW = 3;
    localparam int SC = 4;
    localparam int TW = 6;
    localparam int CW = RB * 2 * SW;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] chal  = '0;
    logic          fin_a = 1'b0;
    logic          fin_b = 1'b0;
    logic          busy, done, tie, tmo, ro_en, cnt_clr, cnt_en;
    logic [RB-1:0] resp;
    logic [SW-1:0] sel_a, sel_b;

    int            checks   = 0;
    int            errors   = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    int            mri      = 0;
    int            da[RB];
    int            db[RB];
    logic [CW-1:0] chal_m   = '0;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(
        .RESP_BITS  (RB),
        .SEL_W      (SW),
        .SETTLE_CYC (SC),
        .TIMEOUT_W  (TW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_challenge (chal),
        .i_fin_a     (fin_a),
        .i_fin_b     (fin_b),
        .o_busy      (busy),
        .o_done      (done),
        .o_response  (resp),
        .o_tie_err   (tie),
        .o_tmo_err   (tmo),
        .o_mux_sel_a (sel_a),
        .o_mux_sel_b (sel_b),
        .o_ro_en     (ro_en),
        .o_cnt_clr   (cnt_clr),
        .o_cnt_en    (cnt_en)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Race outcomes from the programmed finish delays (0 = counter never finishes).
    // Sooner finisher wins, equal delays tie, no finisher times out.
    function automatic void model(output logic [RB-1:0] r, output logic t, output logic m);
        r = '0;
        t = 1'b0;
        m = 1'b0;
        for (int i = 0; i < RB; i++) begin
            if (da[i] > 0 && db[i] > 0) begin
                if (da[i] < db[i])       r[i] = 1'b1;
                else if (da[i] == db[i]) t = 1'b1;
            end else if (da[i] > 0) begin
                r[i] = 1'b1;
            end else if (db[i] == 0) begin
                m = 1'b1;
            end
        end
    endfunction

    // Edge-counter emulation: counts enabled cycles, raises sticky fin at the programmed count.
    initial begin : emu
        int   rc;
        int   ri;
        logic pen;
        rc = 0; ri = 0; pen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                fin_a = 1'b0; fin_b = 1'b0; rc = 0; ri = 0; pen = 1'b0;
            end else begin
                if (cnt_clr) begin
                    fin_a = 1'b0; fin_b = 1'b0; rc = 0;
                end else if (cnt_en) begin
                    rc++;
                    if (ri < RB) begin
                        if (rc == da[ri]) fin_a = 1'b1;
                        if (rc == db[ri]) fin_b = 1'b1;
                    end
                end
                if (pen && !cnt_en) ri++;
                pen = cnt_en;
                if (done) ri = 0;
            end
        end
    end

    // Per-cycle monitor: control legality, settle length, mux selects, timeout length, results.
    initial begin : mon
        int            setl;
        int            rlen;
        logic          pen;
        logic [SW-1:0] sa, sb;
        logic [RB-1:0] er;
        logic          et, em;
        setl = 0; rlen = 0; pen = 1'b0; sa = '0; sb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mri = 0; setl = 0; rlen = 0; pen = 1'b0;
            end else begin
                if (ro_en && cnt_clr) setl++;
                else if (!ro_en)      setl = 0;
                if (cnt_en) begin
                    chk("race_ctl", {62'b0, cnt_clr, ro_en}, 64'd1);
                    if (!pen) begin
                        chk("settle_len", setl, SC);
                        sa = chal_m[mri*2*SW +: SW];
                        sb = chal_m[mri*2*SW+SW +: SW];
                        chk("sel_a", sel_a, sa);
                        chk("sel_b", sel_b, sb);
                        rlen = 0;
                    end
                    rlen++;
                end else if (pen) begin
                    chk("sel_hold", {sel_a, sel_b}, {sa, sb});
                    if (mri < RB && da[mri] == 0 && db[mri] == 0) chk("tmo_len", rlen, 63);
                    mri++;
                end
                pen = cnt_en;
                if (done) begin
                    done_cnt++;
                    model(er, et, em);
                    chk("done_resp", resp, er);
                    chk("done_tie", tie, et);
                    chk("done_tmo", tmo, em);
                    chk("done_busy", busy, 1);
                    chk("done_races", mri, RB);
                    mri = 0;
                end
            end
        end
    end

    task automatic set_all(input int a, input int b);
        for (int i = 0; i < RB; i++) begin
            da[i] = a;
            db[i] = b;
        end
    endtask

    // One accepted start, optional ignored start pulse mid-run, bounded wait for done.
    task automatic run(input logic [CW-1:0] c, input bit noise);
        int n;
        chal_m = c;
        chal   = c;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chal  = ~c;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (noise && n == 30) start = 1'b1;
            if (noise && n == 31) start = 1'b0;
        end
        chk("done_seen", done, 1);
        exp_done++;
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        @(negedge clk);
        chk("done_count", done_cnt, exp_done);
    endtask

    initial begin : main
        int n;
        set_all(10, 0);
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", resp, 0);
        chk("rst_errs", {tie, tmo}, 0);
        chk("rst_sel", {sel_a, sel_b}, 0);
        chk("rst_ctl", {ro_en, cnt_clr, cnt_en}, 3'b010);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ctl", {busy, ro_en, cnt_clr, cnt_en}, 4'b0010);

        // A always wins
        run(48'h0, 1'b0);
        chk("allA_resp", resp, 8'hFF);
        chk("allA_errs", {tie, tmo}, 0);

        // Alternating winners, zero and non-zero challenges
        for (int i = 0; i < RB; i++) begin
            da[i] = (i % 2 == 0) ? 10 : 20;
            db[i] = (i % 2 == 0) ? 20 : 10;
        end
        run(48'h0, 1'b0);
        chk("alt_resp", resp, 8'h55);
        run(48'h9ABC_DEF0_1234, 1'b0);
        chk("alt2_resp", resp, 8'h55);

        // Tie on bit 3
        set_all(10, 0);
        da[3] = 12;
        db[3] = 12;
        run(48'h1357_9BDF_2468, 1'b0);
        chk("tie_resp", resp, 8'hF7);
        chk("tie_err", tie, 1);
        chk("tie_tmo", tmo, 0);

        // Timeout on bit 0
        set_all(10, 0);
        da[0] = 0;
        run(48'hFEDC_BA98_7654, 1'b0);
        chk("tmo_resp", resp, 8'hFE);
        chk("tmo_err", tmo, 1);
        chk("tmo_tie", tie, 0);

        // Reset mid-RACE of bit 5, then a clean run with an ignored start pulse
        set_all(10, 0);
        chal_m = 48'h0F0F_3C3C_A5A5;
        chal   = chal_m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mri == 5 && cnt_en) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit5", n < 3000, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ctl", {ro_en, cnt_clr, cnt_en}, 3'b010);
        chk("abort_resp", resp, 0);
        chk("abort_sel", {sel_a, sel_b}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", done_cnt, exp_done);
        set_all(20, 10);
        da[6] = 5;
        run(48'h2222_4444_6666, 1'b1);
        chk("clean_resp", resp, 8'h40);
        chk("clean_errs", {tie, tmo}, 0);
        repeat (5) @(negedge clk);
        chk("final_done_cnt", done_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
